// File: rtl/seven_seg_scan_controller_if.sv
// seven_seg_scan_controller_if: host write bus for the seven-segment scan controller
//   wr_en    : one-cycle write strobe
//   wr_data  : 16-bit hex value, nibble k drives digit k
//   wr_blank : bit k forces digit k dark
//   pending  : a write is buffered and not yet displayed
interface seven_seg_scan_controller_if;
   logic        wr_en;
   logic [15:0] wr_data;
   logic [3:0]  wr_blank;
   logic        pending;
   modport master (output wr_en, wr_data, wr_blank, input pending);
   modport slave (input wr_en, wr_data, wr_blank, output pending);
endinterface

// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: 4-digit common-anode seven-segment scanner with frame-aligned double buffering
//   clk, rst_n : clock, asynchronous active-low reset
//   wr         : host write bus (slave modport of seven_seg_scan_controller_if)
//   an         : digit enables, active-low, registered
//   seg        : segments a..g on bits 0..6, active-low, registered
//   frame_tick : one-cycle pulse at the first lit cycle of digit 0
//   SEG_LZB_EN : when defined, leading zeros (digits 3..1) are blanked automatically
module hex_seven_segment_decoder (
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   always_comb begin
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
   end
endmodule

module seven_seg_scan_controller #(
   parameter int DWELL_CYC = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic                        clk,
   input  logic                        rst_n,
   seven_seg_scan_controller_if.slave  wr,
   output logic [3:0]                  an,
   output logic [6:0]                  seg,
   output logic                        frame_tick
);
   localparam int MAXC = DWELL_CYC > BLANK_CYC ? DWELL_CYC : BLANK_CYC;
   localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
   typedef enum logic {BLANK, SHOW} state_t;
   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   sh_data_q, sh_data_d, act_data_q, act_data_d;
   logic [3:0]    sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
   logic          pending_q, pending_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          tick_q, tick_d;
   logic          blank_done, show_done, commit, lit;
   logic [3:0]    nib, dark;
   logic [6:0]    dec;
   hex_seven_segment_decoder u_dec (.hex(nib), .seg(dec));
`ifdef SEG_LZB_EN
   logic z3, z2, z1;
   assign z3 = act_data_d[15:12] == 4'h0;
   assign z2 = z3 & (act_data_d[11:8] == 4'h0);
   assign z1 = z2 & (act_data_d[7:4] == 4'h0);
   assign dark = act_blank_d | {z3, z2, z1, 1'b0};
`else
   assign dark = act_blank_d;
`endif
   always_comb begin
      blank_done = state_q == BLANK && cnt_q == CW'(BLANK_CYC - 1);
      show_done = state_q == SHOW && cnt_q == CW'(DWELL_CYC - 1);
      commit = blank_done && idx_q == 2'd0;
      state_d = blank_done ? SHOW : show_done ? BLANK : state_q;
      cnt_d = (blank_done || show_done) ? '0 : cnt_q + 1'b1;
      idx_d = idx_q + {1'b0, show_done};
      sh_data_d = wr.wr_en ? wr.wr_data : sh_data_q;
      sh_blank_d = wr.wr_en ? wr.wr_blank : sh_blank_q;
      // a write landing on the commit edge bypasses the shadow
      act_data_d = !commit ? act_data_q : wr.wr_en ? wr.wr_data : pending_q ? sh_data_q : act_data_q;
      act_blank_d = !commit ? act_blank_q : wr.wr_en ? wr.wr_blank : pending_q ? sh_blank_q : act_blank_q;
      pending_d = commit ? 1'b0 : wr.wr_en ? 1'b1 : pending_q;
      // outputs are precomputed from next-state values so they switch with the state
      nib = act_data_d[{idx_d, 2'b00} +: 4];
      lit = state_d == SHOW && !dark[idx_d];
      an_d = lit ? ~(4'b0001 << idx_d) : 4'hF;
      seg_d = lit ? dec : 7'h7F;
      tick_d = commit;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BLANK;
         idx_q <= '0;
         cnt_q <= '0;
         sh_data_q <= '0;
         sh_blank_q <= '0;
         act_data_q <= '0;
         act_blank_q <= '0;
         pending_q <= 1'b0;
         an_q <= 4'hF;
         seg_q <= 7'h7F;
         tick_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         sh_data_q <= sh_data_d;
         sh_blank_q <= sh_blank_d;
         act_data_q <= act_data_d;
         act_blank_q <= act_blank_d;
         pending_q <= pending_d;
         an_q <= an_d;
         seg_q <= seg_d;
         tick_q <= tick_d;
      end
   end
   assign an = an_q;
   assign seg = seg_q;
   assign frame_tick = tick_q;
   assign wr.pending = pending_q;
endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb_seven_seg_scan_controller: directed scoreboard bench for seven_seg_scan_controller (DWELL_CYC=4, BLANK_CYC=2)
module tb_seven_seg_scan_controller;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame_tick;
   int          vectors = 0;
   int          errs = 0;
   logic [10:0] sb[$];
   seven_seg_scan_controller_if wr ();
   seven_seg_scan_controller #(.DWELL_CYC(4), .BLANK_CYC(2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wr(wr),
      .an(an),
      .seg(seg),
      .frame_tick(frame_tick)
   );
   always #5 clk = ~clk;
   function automatic logic [6:0] dec(input logic [3:0] h);
      logic [6:0] t[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[h];
   endfunction
   function automatic logic [10:0] exp_digit(input logic [15:0] d, input logic [3:0] b, input int j);
      logic       dk;
      logic [3:0] a;
      dk = b[j];
`ifdef SEG_LZB_EN
      if (j > 0) begin
         logic z;
         z = 1'b1;
         for (int k = j; k < 4; k++) z &= (d[k*4 +: 4] == 4'h0);
         dk |= z;
      end
`endif
      a = ~(4'b0001 << j);
      return dk ? {4'hF, 7'h7F} : {a, dec(d[j*4 +: 4])};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(negedge clk);
   endtask
   task automatic write(input logic [15:0] d, input logic [3:0] b);
      wr.wr_en = 1'b1;
      wr.wr_data = d;
      wr.wr_blank = b;
      step();
      wr.wr_en = 1'b0;
   endtask
   task automatic expect_val(input logic [15:0] d, input logic [3:0] b);
      for (int j = 0; j < 4; j++) sb.push_back(exp_digit(d, b, j));
   endtask
   task automatic check_frame(input string tag);
      int k;
      logic [10:0] e;
      k = 0;
      while (frame_tick !== 1'b1 && k < 100) begin
         step();
         k++;
      end
      chk({tag, "_tick"}, frame_tick, 1);
      chk({tag, "_pending"}, wr.pending, 0);
      for (int j = 0; j < 4; j++) begin
         e = sb.size() > 0 ? sb.pop_front() : 11'h000;
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s_d%0d", tag, j), {an, seg}, e);
            step();
         end
         for (int c = 0; c < 2; c++) begin
            chk($sformatf("%s_gap%0d", tag, j), {an, seg}, 11'h7FF);
            step();
         end
      end
      chk({tag, "_period"}, frame_tick, 1);
   endtask
   initial begin
      logic [10:0] e;
      int p;
      wr.wr_en = 1'b0;
      wr.wr_data = '0;
      wr.wr_blank = '0;
      repeat (3) step();
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_tick", frame_tick, 0);
      chk("rst_pending", wr.pending, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 48; i++) begin
         step();
         p = (i + 1) % 24;
         e = (p >= 2 && (p - 2) % 6 < 4) ? exp_digit(16'h0000, 4'h0, (p - 2) / 6) : 11'h7FF;
         chk($sformatf("scan_an_%0d", i), an, e[10:7]);
         chk($sformatf("scan_tick_%0d", i), frame_tick, p == 2);
      end
      write(16'h1A3F, 4'h0);
      chk("wr1a3f_pending", wr.pending, 1);
      expect_val(16'h1A3F, 4'h0);
      check_frame("v1a3f");
      write(16'h1234, 4'h0);
      chk("wr1234_pending", wr.pending, 1);
      repeat (3) step();
      write(16'h5678, 4'h0);
      expect_val(16'h5678, 4'h0);
      check_frame("v5678");
      repeat (23) step();
      expect_val(16'hC0DE, 4'h0);
      write(16'hC0DE, 4'h0);
      check_frame("bypass");
      write(16'h8888, 4'b0100);
      expect_val(16'h8888, 4'b0100);
      check_frame("blank2");
      write(16'h0005, 4'h0);
      expect_val(16'h0005, 4'h0);
      check_frame("v0005");
      write(16'h0000, 4'h0);
      expect_val(16'h0000, 4'h0);
      check_frame("v0000");
      write(16'h9999, 4'h0);
      chk("wr9999_pending", wr.pending, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_an", an, 4'hF);
      chk("midrst_seg", seg, 7'h7F);
      chk("midrst_pending", wr.pending, 0);
      repeat (2) step();
      rst_n = 1'b1;
      expect_val(16'h0000, 4'h0);
      check_frame("postrst");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/seven_seg_scan_controller.md
# seven_seg_scan_controller

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It holds a 16-bit hex value plus per-digit blank mask and walks the digits one at a time, with a blanking gap between digits to suppress ghosting. Each nibble is decoded through the team's `hex_seven_segment_decoder`. Host writes are double-buffered and take effect only at a frame boundary, so the display never shows a torn value.

## Interface
- `DWELL_CYC`, default 50000: clock cycles each digit is lit; must be ≥1.
- `BLANK_CYC`, default 500: clock cycles of all-off gap before each digit; must be ≥1.
- `clk`  input  1: single clock, rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `wr_en`  input  1: write strobe, one cycle, no back-pressure.
- `wr_data`  input  16: hex value; nibble k drives digit k (digit 0 = least significant).
- `wr_blank`  input  4: bit k = 1 forces digit k dark.
- `an`  output  4: digit enables, active-low, registered.
- `seg`  output  7: segments, active-low, bit 0 = a … bit 6 = g, registered.
- `frame_tick`  output  1: one-cycle pulse at each frame start.
- `pending`  output  1: a write is buffered and not yet displayed.

## Operation
- Registers: shadow {data, blank}, active {data, blank}, `pending`, digit index `idx` (2 bits), cycle counter `cnt`, state ∈ {BLANK, SHOW}.
- Reset (async, `rst_n`=0): state=BLANK, idx=0, cnt=0, shadow=active=0, pending=0, `an`=4'b1111, `seg`=7'h7F, `frame_tick`=0.
- BLANK: `an`=4'b1111, `seg`=7'h7F. When cnt==BLANK_CYC-1: cnt←0, state←SHOW.
- SHOW: `an`=one-cold at bit idx; `seg`=decode(active nibble idx). If digit idx is blanked: `an`=4'b1111, `seg`=7'h7F for the whole dwell (timing unchanged). When cnt==DWELL_CYC-1: cnt←0, idx←idx+1 mod 4 (3 wraps to 0), state←BLANK.
- Decode (active-low): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex).
- Write: `wr_en`=1 loads shadow from `wr_data`/`wr_blank` and sets pending. Back-to-back writes: last one wins.
- Commit: on the BLANK→SHOW transition with idx==0, if pending: active←shadow, pending←0. `frame_tick` pulses on every such transition, whether or not a commit occurs.
- Write in the commit cycle: the new write bypasses the shadow into active, and pending ends at 0.

## Timing
- `an`/`seg` change on the same edge as the state change: SHOW lasts exactly DWELL_CYC cycles and BLANK exactly BLANK_CYC cycles. Frame = 4·(DWELL_CYC+BLANK_CYC) cycles.
- After reset release, the first SHOW of digit 0 begins BLANK_CYC cycles after the first active edge. `frame_tick` is high during that first SHOW cycle.
- `pending` rises the cycle after `wr_en`. Write-to-visible latency is at most one frame plus BLANK_CYC.
- Reset mid-frame: outputs go dark immediately. The buffered write is lost.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking. Starting at digit 3 and moving down, digits whose active nibble is 0 are blanked (OR'd with `wr_blank`) until the first nonzero digit. Digit 0 is never auto-blanked.
- `SEG_LZB_EN` undefined: only `wr_blank` blanks digits.

## Test plan
- Reset with DWELL_CYC=4, BLANK_CYC=2: `an`=1111 and `seg`=7F during reset. After release, the `an` sequence is 1111×2, 1110×4, 1111×2, 1101×4, …, with a period of 24 cycles.
- Write 16'h1A3F, blank=0: after the next frame tick, the segments are 0E (d0), 30 (d1), 08 (d2), 79 (d3). `pending` is 1 from the write until the commit.
- Write 16'h1234 then 16'h5678 within one frame: only 5678 is ever displayed, with no mixed digits.
- Write coincident with the commit edge: the new value is shown in that same frame, and `pending`=0 afterwards.
- wr_blank=4'b0100: digit 2 slot shows `an`=1111 and `seg`=7F for 4 cycles, and the frame period is unchanged.
- With `SEG_LZB_EN`, write 16'h0005: digits 3–1 are dark and digit 0 shows 12. Write 16'h0000: only digit 0 is lit, showing 40. Without the macro, 16'h0005 shows 40,40,40,12.
